// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_pkg
// Brief   : Shared types and constants for the RV32I core front end.
// Revision: 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    // Clears the byte-offset bits so every fetch address is word aligned
    localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;

    // Fetch sequencer states: REQ issues a request, WAIT holds for the response
    typedef enum logic [0:0] {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : fetch_skid_buf
// Brief   : One-entry instruction/PC holding buffer. Catches a fetched word
//           that arrives while decode is stalled. Flush beats load beats pop.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_skid_buf
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            flush,
    input  logic            pop,
    input  logic [XLEN-1:0] load_inst,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc
);

    // Entry storage; a load during a pop refills the entry in the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= load_inst;
            pc    <= load_pc;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Brief   : RV32I instruction fetch stage. Owns the PC, runs a single
//           outstanding request/grant/response transaction to instruction
//           memory and presents a registered instruction to decode.
//           Build option FETCH_SKID_EN adds a one-entry skid buffer so one
//           more fetch can complete while decode is stalled.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemGnt,
    input  logic            ImemRvalid,
    input  logic [XLEN-1:0] ImemRdata,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    output logic [XLEN-1:0] InstD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    fetch_state_e    state;
    fetch_state_e    state_next;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            drop;

    logic            out_valid;
    logic [XLEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc;

    logic            granted;
    logic            rsp_fire;
    logic            deliver;
    logic            out_free;
    logic            req_gate;

    logic            skid_valid;
    logic [XLEN-1:0] skid_inst;
    logic [XLEN-1:0] skid_pc;

    assign granted  = ImemReq && ImemGnt;
    assign rsp_fire = (state == WAIT) && ImemRvalid;
    // A response is kept only if it was not superseded by a redirect
    assign deliver  = rsp_fire && !drop && !PCSrcE;
    // StallD only matters when decode actually holds something
    assign out_free = !out_valid || !StallD;

`ifdef FETCH_SKID_EN
    logic skid_load;
    logic skid_pop;

    // Park the delivery when decode is busy, or when the skid drains into
    // the output register this edge and the new word must take its place
    assign skid_load = deliver && (!out_free || skid_valid);
    assign skid_pop  = out_free && skid_valid;
    assign req_gate  = !skid_valid;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .flush     (PCSrcE),
        .pop       (skid_pop),
        .load_inst (ImemRdata),
        .load_pc   (req_pc),
        .valid     (skid_valid),
        .inst      (skid_inst),
        .pc        (skid_pc)
    );
`else
    // Without a skid, fetching only when the output register will be free
    // guarantees every response has somewhere to land
    assign skid_valid = 1'b0;
    assign skid_inst  = NOP_INST;
    assign skid_pc    = '0;
    assign req_gate   = out_free;
`endif

    // Fetch sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
        end else begin
            state <= state_next;
        end
    end

    // Fetch sequencer next state and request strobe
    always_comb begin
        state_next = state;
        ImemReq    = 1'b0;
        case (state)
            REQ: begin
                ImemReq = req_gate && rst_n;
                if (ImemReq && ImemGnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (ImemRvalid) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = REQ;
            end
        endcase
    end

    assign ImemAddr = pc;

    // Program counter and outstanding-request bookkeeping; redirect wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC & WORD_MASK;
            req_pc <= RESET_PC & WORD_MASK;
            drop   <= 1'b0;
        end else begin
            if (granted) begin
                req_pc <= pc;
            end

            if (PCSrcE) begin
                pc <= PCTargetE & WORD_MASK;
            end else if (granted) begin
                pc <= pc + 32'd4;
            end

            // A request still in flight after a redirect must be discarded
            // when it returns; one returning this cycle is discarded now
            if (PCSrcE && (((state == WAIT) && !ImemRvalid) || granted)) begin
                drop <= 1'b1;
            end else if (rsp_fire) begin
                drop <= 1'b0;
            end
        end
    end

    // Decode-facing output register: skid entry has priority over new data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= NOP_INST;
            out_pc    <= '0;
        end else if (PCSrcE) begin
            out_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid <= 1'b1;
                out_inst  <= skid_inst;
                out_pc    <= skid_pc;
            end else if (deliver) begin
                out_valid <= 1'b1;
                out_inst  <= ImemRdata;
                out_pc    <= req_pc;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    assign ValidD   = out_valid;
    assign InstD    = out_inst;
    assign PCD      = out_pc;
    assign PCPlus4D = out_pc + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_unit
// Brief   : Self-checking bench for fetch_unit with a small instruction
//           memory model and an in-order scoreboard of granted fetches.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic [31:0] InstD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t grant_log[$];

    int          lat = 1;
    bit          chk_lat = 1'b1;
    bit          resp_pending = 1'b0;
    int          resp_wait = 0;
    logic [31:0] resp_addr = '0;
    logic [31:0] hold_addr = 32'h0000_000C;
    int          hold_cnt = 0;
    bit          prev_valid = 1'b0;
    bit          prev_stall = 1'b0;
    int          deliveries = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemGnt    (ImemGnt),
        .ImemRvalid (ImemRvalid),
        .ImemRdata  (ImemRdata),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .StallD     (StallD),
        .InstD      (InstD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // memory model: grant (optionally withheld), respond lat cycles later
    initial begin
        ImemGnt    = 1'b1;
        ImemRvalid = 1'b0;
        ImemRdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            ImemRvalid = 1'b0;
            if (resp_pending) begin
                resp_wait--;
                if (resp_wait <= 0) begin
                    ImemRvalid   = 1'b1;
                    ImemRdata    = inst_of(resp_addr);
                    resp_pending = 1'b0;
                end
            end
            if (ImemReq && ImemAddr == hold_addr && hold_cnt > 0) begin
                ImemGnt = 1'b0;
                hold_cnt--;
            end else begin
                ImemGnt = 1'b1;
            end
        end
    end

    // monitor + scoreboard
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (ValidD && (!prev_valid || !prev_stall)) begin
                deliveries++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got PCD=%h InstD=%h, expected no delivery", PCD, InstD);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (PCD !== e.addr || InstD !== inst_of(e.addr) || PCPlus4D !== e.addr + 32'd4) begin
                        errors++;
                        $display("FAIL sb_data: got PCD=%h InstD=%h PCPlus4D=%h, expected %h %h %h",
                                 PCD, InstD, PCPlus4D, e.addr, inst_of(e.addr), e.addr + 32'd4);
                    end
                    if (chk_lat) begin
                        checks++;
                        if (cyc != e.cyc) begin
                            errors++;
                            $display("FAIL sb_latency: got cycle %0d, expected %0d (pc %h)", cyc, e.cyc, e.addr);
                        end
                    end
                end
            end
            if (ImemReq && ImemGnt) begin
                exp_t g;
                g.addr = ImemAddr;
                g.cyc  = cyc;
                grant_log.push_back(g);
                g.cyc  = cyc + lat + 1;
                sb.push_back(g);
                resp_pending = 1'b1;
                resp_wait    = lat;
                resp_addr    = ImemAddr;
            end
            if (PCSrcE) begin
                sb.delete();
            end
            prev_valid = ValidD;
            prev_stall = StallD;
        end
    end

    task automatic wait_grant(input logic [31:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ImemReq && ImemGnt && ImemAddr == a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_out(input logic [31:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ValidD && PCD == a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        StallD    = 1'b0;
        PCSrcE    = 1'b0;
        PCTargetE = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ImemReq !== 1'b0)            begin errors++; $display("FAIL reset_req: got %b, expected 0", ImemReq); end
        checks++; if (ValidD !== 1'b0)             begin errors++; $display("FAIL reset_valid: got %b, expected 0", ValidD); end
        checks++; if (InstD !== 32'h0000_0013)     begin errors++; $display("FAIL reset_inst: got %h, expected 00000013", InstD); end
        checks++; if (PCD !== 32'h0)               begin errors++; $display("FAIL reset_pcd: got %h, expected 0", PCD); end
        checks++; if (PCPlus4D !== 32'h4)          begin errors++; $display("FAIL reset_pcplus4: got %h, expected 4", PCPlus4D); end
        checks++; if (ImemAddr !== 32'h0)          begin errors++; $display("FAIL reset_addr: got %h, expected 0", ImemAddr); end
        hold_cnt = 3;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin
            errors++;
            $display("FAIL first_req: got req=%b addr=%h, expected 1 00000000", ImemReq, ImemAddr);
        end
    endtask

    task automatic test_sequential;
        logic [31:0] exp_a;
        for (int i = 0; i < 40 && grant_log.size() < 3; i++) @(negedge clk);
        checks++;
        if (grant_log.size() < 3) begin
            errors++;
            $display("FAIL seq_timeout: got %0d grants, expected 3", grant_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                exp_a = 32'(i * 4);
                checks++;
                if (grant_log[i].addr !== exp_a) begin
                    errors++;
                    $display("FAIL seq_addr%0d: got %h, expected %h", i, grant_log[i].addr, exp_a);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (grant_log[i].cyc - grant_log[i-1].cyc != 2) begin
                    errors++;
                    $display("FAIL seq_gap%0d: got %0d cycles, expected 2", i, grant_log[i].cyc - grant_log[i-1].cyc);
                end
            end
        end
    endtask

    task automatic test_gnt_hold;
        int  n = 0;
        bit  seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ImemReq && ImemAddr == 32'hC) begin
                seen = 1'b1;
                break;
            end
        end
        if (seen) begin
            for (int i = 0; i < 10; i++) begin
                if (!(ImemReq && ImemAddr == 32'hC)) break;
                n++;
                if (ImemGnt) break;
                @(negedge clk);
            end
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL gnt_hold: got %0d stable request cycles at 0xC, expected 4", n);
        end
    endtask

    task automatic test_redirect;
        bit ok;
        lat = 2;
        wait_grant(32'h10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL redir_grant: got timeout, expected grant of 0x10"); end
        @(posedge clk);
        #1 PCSrcE = 1'b1; PCTargetE = 32'h100;
        @(posedge clk);
        #1 PCSrcE = 1'b0; lat = 1;
        @(negedge clk);
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL redir_valid: got %b, expected 0", ValidD); end
        checks++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL redir_wait: got req=%b, expected 0 while dropped fetch returns", ImemReq); end
        @(negedge clk);
        checks++;
        if (ImemReq !== 1'b1 || ImemAddr !== 32'h100) begin
            errors++;
            $display("FAIL redir_target: got req=%b addr=%h, expected 1 00000100", ImemReq, ImemAddr);
        end
    endtask

    task automatic test_redirect_same_cycle;
        bit ok;
        wait_grant(32'h104, ok);
        checks++; if (!ok) begin errors++; $display("FAIL same_grant: got timeout, expected grant of 0x104"); end
        @(posedge clk);
        #1 PCSrcE = 1'b1; PCTargetE = 32'h0000_0203;
        @(posedge clk);
        #1 PCSrcE = 1'b0;
        @(negedge clk);
        checks++; if (ValidD !== 1'b0) begin errors++; $display("FAIL same_valid: got %b, expected 0", ValidD); end
        checks++;
        if (ImemReq !== 1'b1 || ImemAddr !== 32'h200) begin
            errors++;
            $display("FAIL same_target: got req=%b addr=%h, expected 1 00000200", ImemReq, ImemAddr);
        end
        wait_out(32'h200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL same_deliver: got timeout, expected PCD=00000200"); end
    endtask

    task automatic test_stall;
        bit          ok = 1'b0;
        logic [31:0] h_inst;
        logic [31:0] h_pc;
        int          req_cycles = 0;
        int          exp_req;
`ifdef FETCH_SKID_EN
        exp_req = 1;
`else
        exp_req = 0;
`endif
        chk_lat = 1'b0;
        for (int i = 0; i < 20 && ValidD; i++) @(negedge clk);
        @(posedge clk);
        #1 StallD = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ValidD) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("FAIL stall_valid: got timeout, expected ValidD=1"); end
        h_inst = InstD;
        h_pc   = PCD;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (ImemReq) req_cycles++;
            checks++;
            if (ValidD !== 1'b1 || InstD !== h_inst || PCD !== h_pc) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b inst=%h pc=%h, expected 1 %h %h", i, ValidD, InstD, PCD, h_inst, h_pc);
            end
        end
        @(posedge clk);
        #1 StallD = 1'b0;
        checks++;
        if (req_cycles != exp_req) begin
            errors++;
            $display("FAIL stall_reqs: got %0d request cycles, expected %0d", req_cycles, exp_req);
        end
        repeat (10) @(negedge clk);
        chk_lat = 1'b1;
    endtask

    task automatic test_wrap;
        bit ok;
        @(posedge clk);
        #1 PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        @(posedge clk);
        #1 PCSrcE = 1'b0;
        wait_grant(32'hFFFF_FFFC, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_grant_hi: got timeout, expected grant of FFFFFFFC"); end
        wait_grant(32'h0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_grant_lo: got timeout, expected grant of 00000000"); end
        wait_out(32'h0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_deliver: got timeout, expected PCD=00000000"); end
        repeat (6) @(negedge clk);
        checks++;
        if (deliveries < 12) begin
            errors++;
            $display("FAIL total_deliveries: got %0d, expected at least 12", deliveries);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_gnt_hold();
        test_redirect();
        test_redirect_same_cycle();
        test_stall();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
